mips_multicycle_ctrl: RTL

Moore/Mealy control FSM that sequences a multi-cycle MIPS datapath sharing one unified memory and one ALU across fetch, decode, execute, memory and writeback steps. Replaces the single-cycle opcode decoder.
Adds a variable-latency memory handshake, a bus-timeout watchdog, and retire accounting. Drives datapath muxes, write enables and ALU select each cycle.

---
 rtl/mips_ctrl_pkg.sv | 63 ++++++
 rtl/mips_alu_sel_decode.sv | 37 +++
 rtl/mips_multicycle_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: state codes, opcode/funct
// values, ALU select and datapath mux codes.
package mips_ctrl_pkg;

  typedef logic [3:0] state_t;

  localparam state_t ST_RST       = 4'd0;
  localparam state_t ST_FETCH     = 4'd1;
  localparam state_t ST_DECODE    = 4'd2;
  localparam state_t ST_R_EXEC    = 4'd3;
  localparam state_t ST_R_WB      = 4'd4;
  localparam state_t ST_I_EXEC    = 4'd5;
  localparam state_t ST_I_WB      = 4'd6;
  localparam state_t ST_MEM_ADDR  = 4'd7;
  localparam state_t ST_MEM_READ  = 4'd8;
  localparam state_t ST_MEM_WB    = 4'd9;
  localparam state_t ST_MEM_WRITE = 4'd10;
  localparam state_t ST_BRANCH    = 4'd11;
  localparam state_t ST_HALT      = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_SLL  = 3'd2;
  localparam logic [2:0] ALU_SRL  = 3'd3;
  localparam logic [2:0] ALU_AND  = 3'd4;
  localparam logic [2:0] ALU_OR   = 3'd5;
  localparam logic [2:0] ALU_SLT  = 3'd6;
  localparam logic [2:0] ALU_SLTU = 3'd7;

  localparam logic [1:0] SRCB_REGB   = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_S2 = 2'd3;

  localparam logic [1:0] MSZ_NONE  = 2'd0;
  localparam logic [1:0] MSZ_WORD  = 2'd1;
  localparam logic [1:0] MSZ_HALF  = 2'd2;
  localparam logic [1:0] MSZ_HALFU = 2'd3;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU);
  endfunction

endpackage

// File: rtl/mips_alu_sel_decode.sv
// Combinational (opcode, funct) -> ALU operation decode; valid flags any
// unsupported opcode or R-type funct.
module mips_alu_sel_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] alu_sel,
  output logic       valid
);

  always_comb begin
    alu_sel = ALU_ADD;
    valid   = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  alu_sel = ALU_ADD;
          FN_SUB:  alu_sel = ALU_SUB;
          FN_SLL:  alu_sel = ALU_SLL;
          FN_SRL:  alu_sel = ALU_SRL;
          FN_AND:  alu_sel = ALU_AND;
          FN_OR:   alu_sel = ALU_OR;
          FN_SLT:  alu_sel = ALU_SLT;
          FN_SLTU: alu_sel = ALU_SLTU;
          default: valid   = 1'b0;
        endcase
      end
      OP_LW, OP_SW, OP_LH, OP_LHU, OP_ADDI: alu_sel = ALU_ADD;
      OP_BEQ:  alu_sel = ALU_SUB;
      OP_ANDI: alu_sel = ALU_AND;
      OP_ORI:  alu_sel = ALU_OR;
      default: valid   = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared memory and ALU, with a memory-wait watchdog and retire counter.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic [1:0]       mem_size,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_sel,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             retire,
  output logic [CNT_W-1:0] instr_count,
  output logic             illegal,
  output logic             bus_error,
  output logic             halted
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t            state;
  state_t            state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic              timeout;
  logic              set_illegal;
  logic              set_bus_error;
  logic [2:0]        dec_alu_sel;
  logic              dec_valid;

  mips_alu_sel_decode u_alu_sel_decode (
    .opcode  (opcode),
    .funct   (funct),
    .alu_sel (dec_alu_sel),
    .valid   (dec_valid)
  );

  // Timeout fires on the last permitted wait cycle; mem_ready in that cycle still wins.
  always_comb begin
    state_next    = state;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_size      = MSZ_NONE;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_src        = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REGB;
    alu_sel       = ALU_ADD;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    retire        = 1'b0;
    halted        = 1'b0;
    set_illegal   = 1'b0;
    set_bus_error = 1'b0;
    timeout       = (MEM_TIMEOUT != 0) && (wait_cnt == WAIT_LAST);
    case (state)
      ST_RST: state_next = ST_FETCH;
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          alu_src_b  = SRCB_FOUR;
          state_next = ST_DECODE;
        end else if (timeout) begin
          set_bus_error = 1'b1;
          state_next    = ST_HALT;
        end else begin
          state_next = ST_FETCH;
        end
      end
      ST_DECODE: begin
        alu_src_b = SRCB_IMM_S2;
        case (opcode)
          OP_RTYPE:                     state_next = ST_R_EXEC;
          OP_LW, OP_SW, OP_LH, OP_LHU:  state_next = ST_MEM_ADDR;
          OP_BEQ:                       state_next = ST_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI:     state_next = ST_I_EXEC;
          default: begin
            set_illegal = 1'b1;
            state_next  = ST_HALT;
          end
        endcase
      end
      ST_R_EXEC: begin
        alu_src_a = 1'b1;
        if (dec_valid) begin
          alu_sel    = dec_alu_sel;
          state_next = ST_R_WB;
        end else begin
          set_illegal = 1'b1;
          state_next  = ST_HALT;
        end
      end
      ST_R_WB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_next = ST_FETCH;
      end
      ST_I_EXEC: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        alu_sel    = dec_alu_sel;
        state_next = ST_I_WB;
      end
      ST_I_WB: begin
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_next = ST_FETCH;
      end
      ST_MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        state_next = is_load(opcode) ? ST_MEM_READ : ST_MEM_WRITE;
      end
      ST_MEM_READ: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        case (opcode)
          OP_LW:   mem_size = MSZ_WORD;
          OP_LH:   mem_size = MSZ_HALF;
          OP_LHU:  mem_size = MSZ_HALFU;
          default: mem_size = MSZ_NONE;
        endcase
        if (mem_ready) begin
          state_next = ST_MEM_WB;
        end else if (timeout) begin
          set_bus_error = 1'b1;
          state_next    = ST_HALT;
        end else begin
          state_next = ST_MEM_READ;
        end
      end
      ST_MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_next = ST_FETCH;
      end
      ST_MEM_WRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          retire     = 1'b1;
          state_next = ST_FETCH;
        end else if (timeout) begin
          set_bus_error = 1'b1;
          state_next    = ST_HALT;
        end else begin
          state_next = ST_MEM_WRITE;
        end
      end
      ST_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_sel    = ALU_SUB;
        pc_src     = 1'b1;
        pc_write   = zero;
        retire     = 1'b1;
        state_next = ST_FETCH;
      end
      ST_HALT: begin
        halted     = 1'b1;
        state_next = ST_HALT;
      end
      default: state_next = ST_HALT;
    endcase
  end

  // Wait counter restarts on every state change, so each memory state gets a fresh budget.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_RST;
      wait_cnt    <= '0;
      instr_count <= '0;
      illegal     <= 1'b0;
      bus_error   <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next != state) begin
        wait_cnt <= '0;
      end else if (mem_req && !mem_ready) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end else begin
        wait_cnt <= wait_cnt;
      end
      if (retire) begin
        instr_count <= instr_count + CNT_W'(1);
      end else begin
        instr_count <= instr_count;
      end
      illegal   <= illegal | set_illegal;
      bus_error <= bus_error | set_bus_error;
    end
  end

endmodule
